// File: rtl/spi_device_pkg.sv
// Shared types and constants for the SPI device responder.
//   spi_dev_state_e : frame state (IDLE while CS high, ACTIVE during a frame)
//   SpiByteW        : bits per SPI transfer
//   DefaultIdleByte : byte shifted out when nothing is queued for transmit
package spi_device_pkg;

  localparam int unsigned SpiByteW = 8;
  localparam int unsigned SpiCntW  = $clog2(SpiByteW);
  localparam logic [SpiByteW-1:0] DefaultIdleByte = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_dev_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered edge pulses.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronised level (last synchroniser stage)
//   rise, fall : one-cycle pulses, SyncStages+1 cycles after the pin edge
module spi_sync_edge #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SyncStages{ResetVal}};
      prev_q <= ResetVal;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], din};
      prev_q <= sync_q[SyncStages-1];
      rise   <= sync_q[SyncStages-1] & ~prev_q;
      fall   <= ~sync_q[SyncStages-1] & prev_q;
    end
  end

  assign level = sync_q[SyncStages-1];

endmodule

// File: rtl/spi_device_responder.sv
// SPI mode-0 responder, MSB first, oversampling SCK/CS/MOSI on clk_sys_i.
//   clk_sys_i, rst_sys_ni          : system clock, async active-low reset
//   spi_sck_i, spi_cs_ni, spi_mosi_i : host-side SPI pins
//   spi_miso_o                     : responder data out (0 while idle)
//   rx_data_o/rx_valid_o/rx_ready_i : received byte handshake
//   rx_overrun_o, overrun_clr_i    : sticky dropped-byte flag and its clear
//   tx_data_i/tx_valid_i/tx_ready_o : one-deep TX holding register
//   busy_o                         : registered copy of synchronised CS
module spi_device_responder
  import spi_device_pkg::*;
#(
  parameter int unsigned          SyncStages = 2,
  parameter logic [SpiByteW-1:0]  IdleByte   = DefaultIdleByte
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic                spi_sck_i,
  input  logic                spi_cs_ni,
  input  logic                spi_mosi_i,
  output logic                spi_miso_o,
  output logic [SpiByteW-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                rx_overrun_o,
  input  logic                overrun_clr_i,
  input  logic [SpiByteW-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                busy_o
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sck (
    .clk(clk_sys_i), .rst_n(rst_sys_ni), .din(spi_sck_i),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // CS synchroniser resets high so leaving reset never looks like a frame start.
  spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
    .clk(clk_sys_i), .rst_n(rst_sys_ni), .din(spi_cs_ni),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
    .clk(clk_sys_i), .rst_n(rst_sys_ni), .din(spi_mosi_i),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_dev_state_e state_q, state_d;
  logic start_frame, end_frame, bit_rise, bit_fall;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // CS rise wins over an SCK edge detected in the same cycle.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    bit_rise    = 1'b0;
    bit_fall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else begin
          bit_rise = sck_rise;
          bit_fall = sck_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [SpiCntW-1:0]  bit_cnt_q;
  logic [SpiByteW-1:0] rx_shift_q, tx_shift_q, hold_q, rx_byte, load_byte;
  logic                hold_full_q;
  logic                byte_done, tx_load, tx_push, rx_accept, rx_drop;

  assign rx_byte   = {rx_shift_q[SpiByteW-2:0], mosi_level};
  assign byte_done = bit_rise && (bit_cnt_q == SpiCntW'(SpiByteW - 1));
  assign tx_load   = start_frame || (bit_fall && (bit_cnt_q == '0));
  assign load_byte = hold_full_q ? hold_q : IdleByte;
  assign tx_push   = tx_valid_i && !hold_full_q;
  assign rx_accept = byte_done && (!rx_valid_o || rx_ready_i);
  assign rx_drop   = byte_done && !rx_accept;
  assign tx_ready_o = ~hold_full_q;

  // Receive shifter and bit counter; a CS rise discards any partial byte.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
    end else if (end_frame) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
    end else if (bit_rise) begin
      bit_cnt_q  <= bit_cnt_q + SpiCntW'(1);
      rx_shift_q <= rx_byte;
    end
  end

  // Transmit shifter: reload at frame start and at every byte boundary.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      tx_shift_q <= '0;
      spi_miso_o <= 1'b0;
    end else if (tx_load) begin
      tx_shift_q <= load_byte;
      spi_miso_o <= load_byte[SpiByteW-1];
    end else if (bit_fall) begin
      tx_shift_q <= {tx_shift_q[SpiByteW-2:0], 1'b0};
      spi_miso_o <= tx_shift_q[SpiByteW-2];
    end else if (end_frame) begin
      spi_miso_o <= 1'b0;
    end
  end

  // Push and consume are exclusive because push requires an empty register.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (tx_push) begin
      hold_q      <= tx_data_i;
      hold_full_q <= 1'b1;
    end else if (tx_load && hold_full_q) begin
      hold_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      busy_o <= ~cs_level;
      if (rx_accept) begin
        rx_data_o  <= rx_byte;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (rx_drop)            rx_overrun_o <= 1'b1;
      else if (overrun_clr_i) rx_overrun_o <= 1'b0;
    end
  end

endmodule

// File: doc/spi_device_responder.md
# spi_device_responder

SPI device (responder) that sits on the far side of the demo system's SPI host pins and turns the host's serial traffic into byte transfers on the system clock. It is mode 0 (CPOL=0, CPHA=0), MSB first, full-duplex: one received byte per 8 SCK rising edges and one transmitted byte per frame slot. Benches and FPGA loopback builds use it as the target on `spi_tx_o`/`spi_sck_o`/`spi_rx_i`, with chip-select supplied from a GPO bit. It oversamples SCK in the `clk_sys_i` domain and does not use SCK as a clock.

## Interface
Parameters:
- `SyncStages`, 2 — synchroniser depth on SCK, CS and MOSI (≥2).
- `IdleByte`, 8'hFF — byte shifted out when no TX byte is queued.

Ports:
- `clk_sys_i` in 1 — system clock; single clock domain.
- `rst_sys_ni` in 1 — reset, asynchronous, active-low.
- `spi_sck_i` in 1 — SPI clock from host (`spi_sck_o`).
- `spi_cs_ni` in 1 — chip select, active-low (from a GPO bit).
- `spi_mosi_i` in 1 — host data out (`spi_tx_o`).
- `spi_miso_o` out 1 — responder data out (to `spi_rx_i`).
- `rx_data_o` out 8 — last received byte.
- `rx_valid_o` out 1 — `rx_data_o` holds an unconsumed byte.
- `rx_ready_i` in 1 — consumer accepts `rx_data_o`.
- `rx_overrun_o` out 1 — sticky: a byte was dropped.
- `overrun_clr_i` in 1 — clears `rx_overrun_o`.
- `tx_data_i` in 8 — next byte to send.
- `tx_valid_i` in 1 — `tx_data_i` offered.
- `tx_ready_o` out 1 — TX holding register empty.
- `busy_o` out 1 — synchronised CS asserted (frame in progress).

## Operation
- Reset values: `spi_miso_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `rx_overrun_o`=0, `tx_ready_o`=1, `busy_o`=0; internal state IDLE; bit counter 0.
- States:
  - IDLE — entered when CS is high; `spi_miso_o`=0.
  - ACTIVE — entered on the synchronised CS falling edge.
  - IDLE←ACTIVE on the synchronised CS rising edge, from any bit position.
- On CS fall:
  - Load the TX shift register from the holding register if full (holding register becomes empty), else from `IdleByte`.
  - Drive the MSB on `spi_miso_o`.
- Synchronised SCK rising edge, ACTIVE only:
  - Shift `spi_mosi_i` into the RX shift register (LSB-in).
  - Increment the 3-bit counter.
  - On the wrap 7→0 the byte is complete.
- Synchronised SCK falling edge, ACTIVE only:
  - Counter ≠ 0: shift TX left and drive the next bit.
  - Counter = 0 (byte boundary): reload TX from holding/`IdleByte` and drive its MSB.
- Byte complete handling:
  - `rx_valid_o`=0, or `rx_ready_i`=1 in the same cycle: write `rx_data_o` and set `rx_valid_o`.
  - Otherwise: keep the old byte, drop the new one, set `rx_overrun_o`.
- Handshakes:
  - RX: `rx_valid_o` clears on `rx_valid_o && rx_ready_i` unless a new byte lands in that same cycle.
  - TX: a transfer occurs on `tx_valid_i && tx_ready_o`; `tx_valid_i` while `tx_ready_o`=0 is ignored.
  - A holding-register consume and a push never coincide: ready is low while full. `tx_ready_o` rises the cycle after consume.
- CS rise mid-byte:
  - Partial RX bits are discarded; no `rx_valid_o`.
  - Counter → 0.
  - The TX byte in flight is lost (not re-queued).
  - The holding register is untouched.
- `overrun_clr_i` and a new overrun in the same cycle: the flag stays set.
- SCK edges while CS is high are ignored.

## Timing
- Input constraint: SCK high and low phases ≥ `SyncStages`+2 `clk_sys_i` cycles.
- Edge detect: the edge is visible `SyncStages`+1 cycles after the pin transition.
- RX latency: `rx_valid_o` is high 1 cycle after the 8th detected rising edge.
- MISO latency: `spi_miso_o` updates 1 cycle after the detected falling edge (or CS fall). Total ≤ `SyncStages`+2 cycles, inside the half-period budget.
- `busy_o` follows synchronised CS with 1 cycle of register delay.

## Structure
- Package `spi_device_pkg`:
  - `spi_dev_state_e` (IDLE, ACTIVE).
  - `SpiByteW`=8 constant.
  - Default `IdleByte`.
- Sub-module `spi_sync_edge`:
  - `SyncStages`-flop synchroniser plus registered rise/fall pulse outputs.
  - Instantiated three times (SCK, CS, MOSI; MOSI uses only the level).

## Test plan
- Reset, host sends 8'hA5 with `tx_valid_i` never asserted → `rx_data_o`=8'hA5 and `rx_valid_o`=1, 1 cycle after the 8th rise; MISO returns 8'hFF.
- Push 8'h3C then 8'hC3 (second after `tx_ready_o` rises); host sends a 2-byte frame 8'h12, 8'h34 → MISO 8'h3C, 8'hC3; RX 8'h12 then 8'h34, with `rx_ready_i` held 1.
- `rx_ready_i`=0 for 2 bytes (8'h11, 8'h22) → `rx_data_o`=8'h11 and `rx_overrun_o`=1; pulse `overrun_clr_i` → flag 0.
- `rx_ready_i`=1 in the exact cycle byte 2 completes → no overrun; `rx_data_o`=second byte.
- CS rises after 5 SCK rises → no `rx_valid_o`; next full frame 8'h5A is received correctly; queued TX byte is sent in the new frame.
- Assert `rst_sys_ni`=0 mid-byte → all outputs at reset values immediately (asynchronous); a subsequent frame works normally.
